fib_readback_checker: RTL

//  Read-side checker for the ALU/regfile Fibonacci bring-up test. After the test sequencer has written r0..r15,

---
 rtl/fib_readback_checker.sv | 75 +++++++
 1 files changed

// File: rtl/fib_readback_checker.sv
// fib_readback_checker: steps rd_sel over r0..r(NUM_REGS-1) and checks each read against a scaled Fibonacci sequence
module fib_readback_checker #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int SEED     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] rd_data,
    output logic [3:0]        rd_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [4:0]        err_count,
    output logic              first_err_vld,
    output logic [3:0]        first_err_idx
);
    typedef enum logic [1:0] {IDLE, PRIME, CHECK, DONE} state_t;
    state_t state;
    logic [DATA_W-1:0] prev, cur;
    logic miss;
    assign miss = rd_data != cur;
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rd_sel        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            prev          <= '0;
            cur           <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state         <= PRIME;
                    rd_sel        <= '0;
                    busy          <= 1'b1;
                    done          <= 1'b0;
                    pass          <= 1'b0;
                    err_count     <= '0;
                    first_err_vld <= 1'b0;
                    first_err_idx <= '0;
                    prev          <= '0;
                    cur           <= DATA_W'(SEED);
                end
                PRIME: state <= CHECK;
                CHECK: begin
                    if (miss) begin
                        err_count <= err_count + 5'd1;
                        if (!first_err_vld) begin
                            first_err_vld <= 1'b1;
                            first_err_idx <= rd_sel;
                        end
                    end
                    if (rd_sel == 4'(NUM_REGS - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // the final compare is still in flight, so fold it into pass here
                        pass  <= (err_count == 5'd0) && !miss;
                    end else begin
                        rd_sel <= rd_sel + 4'd1;
                        prev   <= cur;
                        cur    <= prev + cur;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
